serial_result_collector: RTL

// - Receive end of the bit-serial add/subtract datapath.
// - Accepts the LSB-first sum bit stream plus the final carry from the serial adder core.
// - Assembles the BIT_WIDTH+1 parallel result (A+B or A-B).
// - Presents the result through a valid/ready handshake to the next stage (top-level sum port, checker).

---
 rtl/serial_result_collector.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_result_collector.sv
// Receive end of the bit-serial add/subtract datapath: gathers LSB-first sum bits
// plus the final carry into a BIT_WIDTH+1 result offered over a valid/ready handshake.
module serial_result_collector #(
   parameter int unsigned BIT_WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 M,
   input  logic                 bit_valid,
   input  logic                 bit_in,
   input  logic                 carry_in,
   output logic [BIT_WIDTH:0]   result,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic                 busy
);

   localparam int unsigned CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t               state_q;
   logic [BIT_WIDTH-1:0] shreg_q;
   logic [BIT_WIDTH-1:0] shreg_d;
   logic [CNT_W-1:0]     cnt_q;
   logic                 m_q;
   logic                 last_bit_c;

   // New bits enter at the top so the first (LSB) bit ends up in shreg[0].
   assign shreg_d    = {bit_in, shreg_q[BIT_WIDTH-1:1]};
   assign last_bit_c = (cnt_q == CNT_W'(BIT_WIDTH - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         m_q          <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= COLLECT;
                  shreg_q <= '0;
                  cnt_q   <= '0;
                  m_q     <= M;
                  busy    <= 1'b1;
               end
            end
            COLLECT: begin
               if (start) begin
                  shreg_q <= '0;
                  cnt_q   <= '0;
                  m_q     <= M;
               end else if (bit_valid) begin
                  shreg_q <= shreg_d;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  if (last_bit_c) begin
                     // In subtract mode the MSB is the borrow, i.e. the inverted carry.
                     result       <= {carry_in ^ m_q, shreg_d};
                     result_valid <= 1'b1;
                     busy         <= 1'b0;
                     cnt_q        <= '0;
                     state_q      <= DONE;
                  end
               end
            end
            DONE: begin
               // A start is only honoured once the held result has been consumed.
               if (result_ready) begin
                  result_valid <= 1'b0;
                  if (start) begin
                     state_q <= COLLECT;
                     shreg_q <= '0;
                     cnt_q   <= '0;
                     m_q     <= M;
                     busy    <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
